arm_block_transfer_seq: RTL and testbench

Sequencer for ARM LDM/STM (block data transfer) instructions in the GBA CPU. Takes the decoded block fields (P, U, S, W, 16-bit register list) plus the base register value when issued by the control unit. Emits one register transfer per memory handshake with ascending word addresses, then reports base writeback and completion. Sits between the control unit and the memory/register-file datapath.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/reg_list_scan.sv | 24 ++
 rtl/arm_block_transfer_seq.sv | 163 ++++++++++++++++
 tb/tb_arm_block_transfer_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the block-transfer sequencer and its helpers.
// Holds the sequencer state encoding and the empty-list address offset.
// Pure declarations; no logic.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } block_seq_state_t;

  // An empty register list moves the base as if sixteen words were transferred.
  localparam logic [31:0] BLOCK_EMPTY_LIST_OFFSET = 32'h40;

  // One-hot mask for a register index.
  function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
    reg_onehot = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/reg_list_scan.sv
// Register-list scanner: popcount, lowest set index and empty flag.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module reg_list_scan (
  input  logic [15:0] list,
  output logic [4:0]  count,
  output logic [3:0]  lowest,
  output logic        none
);

  // Walk from the top down so the last hit is the lowest set bit.
  always_comb begin
    count  = 5'd0;
    lowest = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) begin
        lowest = 4'(i);
        count  = count + 5'd1;
      end
    end
    none = (list == 16'h0000);
  end

endmodule

// File: rtl/arm_block_transfer_seq.sv
// LDM/STM sequencer: one register transfer per memory handshake, ascending addresses.
// Latency: start -> first xfer_valid 2 cycles; done n+2 cycles after start with ready held high.
// Backpressure: xfer_valid/xfer_reg/xfer_addr hold until xfer_ready; all outputs are registered.
module arm_block_transfer_seq
  import cpu_types_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        P,
  input  logic        U,
  input  logic        S,
  input  logic        W,
  input  logic [15:0] reg_list,
  input  logic [3:0]  Rn,
  input  logic [31:0] base,
  output logic        busy,
  output logic        xfer_valid,
  input  logic        xfer_ready,
  output logic [3:0]  xfer_reg,
  output logic [31:0] xfer_addr,
  output logic        xfer_is_load,
  output logic        user_bank,
  output logic        wb_valid,
  output logic [31:0] wb_value,
  output logic        psr_restore,
  output logic        done
);

  block_seq_state_t state;

  logic        l_is_load, l_p, l_u, l_s, l_w;
  logic [15:0] l_list;
  logic [3:0]  l_rn;
  logic [31:0] l_base;
  logic [15:0] work;       // registers still to go, excluding the one on xfer_reg
  logic [31:0] addr;

  logic [4:0]  a_count, w_count;
  logic [3:0]  a_low, w_low;
  logic        a_none, w_none;

  logic [31:0] offset, start_addr, final_base;
  logic [15:0] eff_list;
  logic [3:0]  first_reg;
  logic        last_xfer;

  // Latched list feeds the address arithmetic in SETUP.
  reg_list_scan u_scan_latched (
    .list   (l_list),
    .count  (a_count),
    .lowest (a_low),
    .none   (a_none)
  );

  // Working list picks the next register during XFER.
  reg_list_scan u_scan_work (
    .list   (work),
    .count  (w_count),
    .lowest (w_low),
    .none   (w_none)
  );

  // Start address, final base and first register from the latched fields.
  always_comb begin
    offset    = a_none ? BLOCK_EMPTY_LIST_OFFSET : {25'd0, a_count, 2'b00};
    eff_list  = a_none ? 16'h8000 : l_list;
    first_reg = a_none ? 4'd15 : a_low;
    case ({l_p, l_u})
      2'b01:   start_addr = l_base;
      2'b11:   start_addr = l_base + 32'd4;
      2'b00:   start_addr = l_base - offset + 32'd4;
      default: start_addr = l_base - offset;
    endcase
    final_base = l_u ? (l_base + offset) : (l_base - offset);
    last_xfer  = w_none || (w_count == 5'd0);
  end

  assign xfer_addr = {addr[31:2], 2'b00};

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      l_is_load    <= 1'b0;
      l_p          <= 1'b0;
      l_u          <= 1'b0;
      l_s          <= 1'b0;
      l_w          <= 1'b0;
      l_list       <= 16'h0000;
      l_rn         <= 4'd0;
      l_base       <= 32'd0;
      work         <= 16'h0000;
      addr         <= 32'd0;
      busy         <= 1'b0;
      xfer_valid   <= 1'b0;
      xfer_reg     <= 4'd0;
      xfer_is_load <= 1'b0;
      user_bank    <= 1'b0;
      wb_valid     <= 1'b0;
      wb_value     <= 32'd0;
      psr_restore  <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            l_is_load    <= is_load;
            l_p          <= P;
            l_u          <= U;
            l_s          <= S;
            l_w          <= W;
            l_list       <= reg_list;
            l_rn         <= Rn;
            l_base       <= base;
            busy         <= 1'b1;
            xfer_is_load <= is_load;
            user_bank    <= S & ~(is_load & reg_list[15]);
            state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          addr       <= start_addr;
          wb_value   <= final_base;
          xfer_reg   <= first_reg;
          work       <= eff_list & ~reg_onehot(first_reg);
          xfer_valid <= 1'b1;
          state      <= ST_XFER;
        end
        ST_XFER: begin
          if (xfer_ready) begin
            addr <= addr + 32'd4;
            if (last_xfer) begin
              xfer_valid  <= 1'b0;
              done        <= 1'b1;
              wb_valid    <= l_w & ~(l_is_load & l_list[l_rn]);
              psr_restore <= l_s & l_is_load & l_list[15];
              state       <= ST_DONE;
            end else begin
              xfer_reg <= w_low;
              work     <= work & ~reg_onehot(w_low);
            end
          end
        end
        default: begin
          done         <= 1'b0;
          wb_valid     <= 1'b0;
          psr_restore  <= 1'b0;
          busy         <= 1'b0;
          user_bank    <= 1'b0;
          xfer_is_load <= 1'b0;
          wb_value     <= 32'd0;
          addr         <= 32'd0;
          xfer_reg     <= 4'd0;
          work         <= 16'h0000;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm_block_transfer_seq.sv
// Directed bench for arm_block_transfer_seq with a queue-based scoreboard.
// Transfers and completions are predicted at issue and checked by a negedge monitor.
// Timing points (busy, first valid, done cycle, stall, reset) are checked inline.
module tb_arm_block_transfer_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_load, P, U, S, W;
  logic [15:0] reg_list;
  logic [3:0]  Rn;
  logic [31:0] base;
  logic        busy, xfer_valid, xfer_ready;
  logic [3:0]  xfer_reg;
  logic [31:0] xfer_addr;
  logic        xfer_is_load, user_bank, wb_valid, psr_restore, done;
  logic [31:0] wb_value;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] a;
    logic        ld;
    logic        ub;
  } xfer_exp_t;

  typedef struct {
    logic        wbv;
    logic [31:0] wbval;
    logic        psr;
  } cmpl_exp_t;

  xfer_exp_t xq[$];
  cmpl_exp_t cq[$];

  int vectors = 0;
  int miscompares = 0;

  arm_block_transfer_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_load      (is_load),
    .P            (P),
    .U            (U),
    .S            (S),
    .W            (W),
    .reg_list     (reg_list),
    .Rn           (Rn),
    .base         (base),
    .busy         (busy),
    .xfer_valid   (xfer_valid),
    .xfer_ready   (xfer_ready),
    .xfer_reg     (xfer_reg),
    .xfer_addr    (xfer_addr),
    .xfer_is_load (xfer_is_load),
    .user_bank    (user_bank),
    .wb_valid     (wb_valid),
    .wb_value     (wb_value),
    .psr_restore  (psr_restore),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_x(input logic [3:0] r, input logic [31:0] a, input logic ld, input logic ub);
    xfer_exp_t e;
    e.r = r; e.a = a; e.ld = ld; e.ub = ub;
    xq.push_back(e);
  endtask

  task automatic push_c(input logic wbv, input logic [31:0] wbval, input logic psr);
    cmpl_exp_t e;
    e.wbv = wbv; e.wbval = wbval; e.psr = psr;
    cq.push_back(e);
  endtask

  // Monitor: pops predictions whenever the DUT presents a handshake or completion.
  always @(negedge clk) begin
    if (!reset) begin
      if (xfer_valid && xfer_ready) begin
        if (xq.size() == 0) begin
          chk("xfer_unexpected", {28'd0, xfer_reg}, 32'hFFFF_FFFF);
        end else begin
          xfer_exp_t e;
          e = xq.pop_front();
          chk("xfer_reg", {28'd0, xfer_reg}, {28'd0, e.r});
          chk("xfer_addr", xfer_addr, e.a);
          chk("xfer_is_load", {31'd0, xfer_is_load}, {31'd0, e.ld});
          chk("user_bank", {31'd0, user_bank}, {31'd0, e.ub});
        end
      end
      if (done) begin
        if (cq.size() == 0) begin
          chk("done_unexpected", {31'd0, done}, 32'd0);
        end else begin
          cmpl_exp_t c;
          c = cq.pop_front();
          chk("wb_valid", {31'd0, wb_valid}, {31'd0, c.wbv});
          chk("psr_restore", {31'd0, psr_restore}, {31'd0, c.psr});
          if (c.wbv) chk("wb_value", wb_value, c.wbval);
        end
      end else begin
        if (wb_valid) chk("wb_without_done", {31'd0, wb_valid}, 32'd0);
        if (psr_restore) chk("psr_without_done", {31'd0, psr_restore}, 32'd0);
      end
    end
  end

  task automatic issue(input logic ld, input logic p, input logic u, input logic s, input logic w,
                       input logic [15:0] lst, input logic [3:0] rn, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; is_load = ld; P = p; U = u; S = s; W = w;
    reg_list = lst; Rn = rn; base = b;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the fields so the DUT must rely on its latched copy.
    reg_list = 16'hFFFF; base = 32'hDEAD_BEEF; Rn = 4'd9;
    is_load = ~ld; P = ~p; U = ~u; S = ~s; W = ~w;
  endtask

  // Issue a sequence and track cycle timing up to and just past DONE.
  task automatic run(input logic ld, input logic p, input logic u, input logic s, input logic w,
                     input logic [15:0] lst, input logic [3:0] rn, input logic [31:0] b,
                     input logic ub, input int exp_done);
    int cyc;
    issue(ld, p, u, s, w, lst, rn, b);
    cyc = 1;
    chk("busy_cycle1", {31'd0, busy}, 32'd1);
    chk("valid_cycle1", {31'd0, xfer_valid}, 32'd0);
    chk("user_bank_cycle1", {31'd0, user_bank}, {31'd0, ub});
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) chk("valid_cycle2", {31'd0, xfer_valid}, 32'd1);
      if (!done) chk("busy_during", {31'd0, busy}, 32'd1);
    end
    chk("done_cycle", cyc, exp_done);
    @(posedge clk); #1;
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_after_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; is_load = 1'b0; P = 1'b0; U = 1'b0; S = 1'b0; W = 1'b0;
    reg_list = 16'h0; Rn = 4'd0; base = 32'd0; xfer_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, xfer_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_addr", xfer_addr, 32'd0);
    reset = 1'b0;
    xfer_ready = 1'b1;

    // STMIA R0!,{R1,R2,R5}
    push_x(4'd1, 32'h0300_0000, 1'b0, 1'b0);
    push_x(4'd2, 32'h0300_0004, 1'b0, 1'b0);
    push_x(4'd5, 32'h0300_0008, 1'b0, 1'b0);
    push_c(1'b1, 32'h0300_000C, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0026, 4'd0, 32'h0300_0000, 1'b0, 5);

    // LDMDB R13!,{R4,R14}
    push_x(4'd4, 32'h0300_7EF8, 1'b1, 1'b0);
    push_x(4'd14, 32'h0300_7EFC, 1'b1, 1'b0);
    push_c(1'b1, 32'h0300_7EF8, 1'b0);
    run(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4010, 4'd13, 32'h0300_7F00, 1'b0, 4);

    // LDMIA R3!,{R3,R7}: base in list, loaded value wins
    push_x(4'd3, 32'h0000_1000, 1'b1, 1'b0);
    push_x(4'd7, 32'h0000_1004, 1'b1, 1'b0);
    push_c(1'b0, 32'h0, 1'b0);
    run(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0088, 4'd3, 32'h0000_1000, 1'b0, 4);

    // LDMIB R2,{R0} without writeback
    push_x(4'd0, 32'h0000_2004, 1'b1, 1'b0);
    push_c(1'b0, 32'h0, 1'b0);
    run(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 4'd2, 32'h0000_2000, 1'b0, 3);

    // Empty list STMIA R1!: transfers R15, base moves by 0x40
    push_x(4'd15, 32'h0000_0100, 1'b0, 1'b0);
    push_c(1'b1, 32'h0000_0140, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd1, 32'h0000_0100, 1'b0, 3);

    // LDMIA with S=1 and {R15}: PSR restore, no user bank
    push_x(4'd15, 32'h0000_0400, 1'b1, 1'b0);
    push_c(1'b0, 32'h0, 1'b1);
    run(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h8000, 4'd4, 32'h0000_0400, 1'b0, 3);

    // STMDA with S=1 {R0,R1}: user bank throughout, base 0x500 -> 0x4F8
    push_x(4'd0, 32'h0000_04FC, 1'b0, 1'b1);
    push_x(4'd1, 32'h0000_0500, 1'b0, 1'b1);
    push_c(1'b1, 32'h0000_04F8, 1'b0);
    run(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 4'd6, 32'h0000_0500, 1'b1, 4);

    // Stall on the second transfer, then reset mid-XFER
    push_x(4'd1, 32'h0000_0600, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h000E, 4'd8, 32'h0000_0600);
    @(posedge clk); #1;                       // cycle 2: R1 accepted
    @(posedge clk); #1;                       // cycle 3: R2 presented
    xfer_ready = 1'b0;
    chk("stall_valid", {31'd0, xfer_valid}, 32'd1);
    chk("stall_reg", {28'd0, xfer_reg}, 32'd2);
    chk("stall_addr", xfer_addr, 32'h0000_0604);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stall_hold_valid", {31'd0, xfer_valid}, 32'd1);
      chk("stall_hold_reg", {28'd0, xfer_reg}, 32'd2);
      chk("stall_hold_addr", xfer_addr, 32'h0000_0604);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, xfer_valid}, 32'd0);
    chk("mid_rst_reg", {28'd0, xfer_reg}, 32'd0);
    chk("mid_rst_addr", xfer_addr, 32'd0);
    chk("mid_rst_wb_value", wb_value, 32'd0);
    chk("mid_rst_flags", {27'd0, done, wb_valid, psr_restore, user_bank, xfer_is_load}, 32'd0);
    xfer_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {30'd0, busy, done}, 32'd0);
    end

    // Fresh sequence after reset: STMIB R8!,{R4}
    push_x(4'd4, 32'h0000_0704, 1'b0, 1'b0);
    push_c(1'b1, 32'h0000_0704, 1'b0);
    run(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 4'd8, 32'h0000_0700, 1'b0, 3);

    repeat (2) @(posedge clk);
    #1;
    chk("xfer_queue_drained", xq.size(), 32'd0);
    chk("cmpl_queue_drained", cq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
